data_mem_lsu: RTL and testbench

//  Data memory for the MEM stage of the five-stage pipeline. Computes the effective address
//  (base + offset) and performs RV32I loads and stores (LB/LH/LW/LBU/LHU, SB/SH/SW) with

---
 rtl/data_mem_lsu.sv | 210 +++++++++++++++++++++
 tb/tb_data_mem_lsu.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_lsu.sv
// Data memory load/store unit for the MEM stage.
// Computes ea = base + offset, performs RV32I byte/half/word loads and stores
// with lane selection and sign/zero extension, flags rejected accesses, and
// returns a registered response exactly one cycle after each accepted request.
// After reset the array is optionally swept to zero before requests are taken.
//
// Handshake: a request transfers on a rising edge where req_valid and req_ready
// are both high; req_ready is high every cycle in RUN and low during the clear
// sweep. resp_valid pulses for one cycle, exactly one cycle after each transfer.

module data_mem_lsu #(
    parameter int DEPTH          = 32,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_base,
    input  logic [31:0] req_offset,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        init_done,
    output logic        o_dbg_state
);

    localparam int          AW    = $clog2(DEPTH);
    localparam logic [31:0] LIMIT = 32'(4 * DEPTH);

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // Registers
    state_t        r_state;
    logic [AW-1:0] r_ptr;
    logic          r_init_done;
    logic          r_resp_valid;
    logic          r_resp_err;
    logic [31:0]   r_resp_rdata;
    logic [31:0]   r_mem [DEPTH];

    // Combinational signals
    state_t        w_next_state;
    logic          w_req_ready;
    logic          w_init_wr;
    logic [31:0]   w_ea;
    logic [AW-1:0] w_word;
    logic [1:0]    w_lane;
    logic          w_illegal;
    logic          w_misalign;
    logic          w_oor;
    logic          w_err;
    logic          w_accept;
    logic          w_do_store;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata_rep;
    logic [31:0]   w_rword;
    logic [7:0]    w_rbyte;
    logic [15:0]   w_rhalf;
    logic [31:0]   w_load_data;

    // State register: reset lands in the sweep or straight in RUN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= (CLEAR_ON_RESET != 0) ? S_INIT : S_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and state outputs: sweep one word per cycle, then accept every cycle
    always_comb begin
        w_next_state = r_state;
        w_req_ready  = 1'b0;
        w_init_wr    = 1'b0;
        case (r_state)
            S_INIT: begin
                w_init_wr = 1'b1;
                if (&r_ptr) begin
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                w_req_ready = 1'b1;
            end
            default: begin
                w_next_state = S_RUN;
            end
        endcase
    end

    // Sweep pointer and init_done flag; init_done sets on the edge that enters RUN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr       <= '0;
            r_init_done <= 1'b0;
        end else begin
            if (w_init_wr) begin
                r_ptr <= r_ptr + 1'b1;
            end
            if (w_next_state == S_RUN) begin
                r_init_done <= 1'b1;
            end
        end
    end

    // Address generation and access checks
    always_comb begin
        w_ea     = req_base + req_offset;
        w_word   = w_ea[AW+1:2];
        w_lane   = w_ea[1:0];
        w_accept = req_valid & w_req_ready;

        w_illegal = 1'b0;
        if (req_we) begin
            w_illegal = req_funct3[2] | (req_funct3[1:0] == 2'b11);
        end else begin
            w_illegal = (req_funct3 == 3'b011) | (req_funct3 == 3'b110) |
                        (req_funct3 == 3'b111);
        end

        w_misalign = 1'b0;
        if (req_funct3[1:0] == 2'b01) begin
            w_misalign = w_ea[0];
        end else if (req_funct3[1:0] == 2'b10) begin
            w_misalign = (w_ea[1:0] != 2'b00);
        end

        w_oor      = (w_ea >= LIMIT);
        w_err      = w_illegal | w_misalign | w_oor;
        w_do_store = w_accept & req_we & ~w_err;
    end

    // Store lane enables and store data replicated onto every lane
    always_comb begin
        w_be        = 4'b0000;
        w_wdata_rep = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                w_be        = 4'b0001 << w_lane;
                w_wdata_rep = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                w_be        = w_lane[1] ? 4'b1100 : 4'b0011;
                w_wdata_rep = {2{req_wdata[15:0]}};
            end
            default: begin
                w_be        = 4'b1111;
                w_wdata_rep = req_wdata;
            end
        endcase
    end

    // Memory array: zero fill during the sweep, byte-enabled stores in RUN
    always_ff @(posedge clk) begin
        if (w_init_wr) begin
            r_mem[r_ptr] <= '0;
        end else if (w_do_store) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_word][8*b +: 8] <= w_wdata_rep[8*b +: 8];
                end
            end
        end
    end

    // Load lane select and extension; stores land on the same edge so a
    // following load naturally sees them without any bypass
    always_comb begin
        w_rword     = r_mem[w_word];
        w_rbyte     = w_rword[8*w_lane +: 8];
        w_rhalf     = w_lane[1] ? w_rword[31:16] : w_rword[15:0];
        w_load_data = '0;
        case (req_funct3)
            3'b000:  w_load_data = {{24{w_rbyte[7]}}, w_rbyte};
            3'b001:  w_load_data = {{16{w_rhalf[15]}}, w_rhalf};
            3'b010:  w_load_data = w_rword;
            3'b100:  w_load_data = {24'h0, w_rbyte};
            3'b101:  w_load_data = {16'h0, w_rhalf};
            default: w_load_data = '0;
        endcase
    end

    // Response register: one cycle after every accept; data only for good loads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
        end else begin
            r_resp_valid <= w_accept;
            r_resp_err   <= w_accept & w_err;
            r_resp_rdata <= (w_accept & ~req_we & ~w_err) ? w_load_data : 32'h0;
        end
    end

    assign req_ready   = w_req_ready;
    assign resp_valid  = r_resp_valid;
    assign resp_err    = r_resp_err;
    assign resp_rdata  = r_resp_rdata;
    assign init_done   = r_init_done;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Testbench for data_mem_lsu: byte-addressed reference memory, scoreboard queue
// of expected responses, and a monitor that checks every response cycle.

module tb_data_mem_lsu;

  localparam int DEPTH = 32;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_base;
  logic [31:0] req_offset;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        init_done;
  logic        dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [32:0] exp_q[$];
  logic [7:0]  ref_mem [4*DEPTH];
  logic        acc_prev;

  data_mem_lsu #(.DEPTH(DEPTH), .CLEAR_ON_RESET(1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_funct3  (req_funct3),
    .req_base    (req_base),
    .req_offset  (req_offset),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .init_done   (init_done),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // a response is due in every cycle after the bench drove req_valid
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_prev <= 1'b0;
    else        acc_prev <= req_valid;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // reference model: byte-addressed little-endian memory, rules applied directly
  function automatic logic [32:0] model(input logic we, input logic [2:0] f3,
                                       input logic [31:0] ea, input logic [31:0] wd);
    int unsigned sz;
    logic        sgn;
    logic        legal;
    logic [31:0] val;
    sz = 1; sgn = 1'b0; legal = 1'b1;
    if (we) begin
      case (f3)
        3'd0: sz = 1;
        3'd1: sz = 2;
        3'd2: sz = 4;
        default: legal = 1'b0;
      endcase
    end else begin
      case (f3)
        3'd0: begin sz = 1; sgn = 1'b1; end
        3'd1: begin sz = 2; sgn = 1'b1; end
        3'd2: sz = 4;
        3'd4: sz = 1;
        3'd5: sz = 2;
        default: legal = 1'b0;
      endcase
    end
    if (!legal || (ea % sz) != 0 || ea >= 4*DEPTH) return {1'b1, 32'h0};
    if (we) begin
      for (int b = 0; b < int'(sz); b++) ref_mem[ea + b] = wd[8*b +: 8];
      return {1'b0, 32'h0};
    end
    val = 32'h0;
    for (int b = 0; b < int'(sz); b++) val = val | (32'(ref_mem[ea + b]) << (8*b));
    if (sgn && val[8*sz-1]) val = val | ~((32'h1 << (8*sz)) - 1);
    return {1'b0, val};
  endfunction

  // driver tasks
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] base,
                       input logic [31:0] off, input logic [31:0] wd);
    logic [32:0] e;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3;
    req_base = base; req_offset = off; req_wdata = wd;
    e = model(we, f3, base + off, wd);
    exp_q.push_back(e);
  endtask

  task automatic issue_exp(input logic we, input logic [2:0] f3, input logic [31:0] base,
                           input logic [31:0] off, input logic [31:0] wd,
                           input logic exp_err, input logic [31:0] exp_data);
    logic [32:0] e;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3;
    req_base = base; req_offset = off; req_wdata = wd;
    e = model(we, f3, base + off, wd);
    exp_q.push_back({exp_err, exp_data});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
  endtask

  // called right after rst_n is released: sweep must take exactly DEPTH edges
  task automatic wait_init();
    for (int k = 1; k <= DEPTH; k++) begin
      @(posedge clk);
      #1;
      if (k < DEPTH) begin
        check($sformatf("init_done_cyc%0d", k), 32'(init_done), 32'h0);
        check($sformatf("req_ready_cyc%0d", k), 32'(req_ready), 32'h0);
      end else begin
        check("init_done_final", 32'(init_done), 32'h1);
        check("req_ready_final", 32'(req_ready), 32'h1);
      end
    end
    for (int i = 0; i < 4*DEPTH; i++) ref_mem[i] = 8'h00;
  endtask

  // scoreboard monitor
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("resp_valid", 32'(resp_valid), 32'(acc_prev));
        if (resp_valid) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL resp_unexpected: got resp_valid=1, required no response");
          end else begin
            e = exp_q.pop_front();
            check("resp_err", 32'(resp_err), 32'(e[32]));
            check("resp_rdata", resp_rdata, e[31:0]);
          end
        end
      end
    end
  end

  // stimulus
  initial begin
    logic [31:0] ea_t, off, wd;
    logic [2:0]  f3;
    logic        we;

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_base = '0; req_offset = '0; req_wdata = '0;
    for (int i = 0; i < 4*DEPTH; i++) ref_mem[i] = 8'h00;
    #1;
    check("rst_resp_valid", 32'(resp_valid), 32'h0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_resp_err", 32'(resp_err), 32'h0);
    check("rst_init_done", 32'(init_done), 32'h0);
    check("rst_req_ready", 32'(req_ready), 32'h0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_init();

    // every word reads zero after the sweep
    for (int i = 0; i < DEPTH; i++) issue_exp(1'b0, 3'd2, 32'(4*i), 32'h0, 32'h0, 1'b0, 32'h0);

    // word store then lane loads
    issue_exp(1'b1, 3'd2, 32'h10, 32'h4, 32'hDEADBEEF, 1'b0, 32'h0);
    issue_exp(1'b0, 3'd2, 32'h14, 32'h0, 32'h0, 1'b0, 32'hDEADBEEF);
    issue_exp(1'b0, 3'd0, 32'h14, 32'h0, 32'h0, 1'b0, 32'hFFFFFFEF);
    issue_exp(1'b0, 3'd4, 32'h17, 32'h0, 32'h0, 1'b0, 32'h000000DE);
    issue_exp(1'b0, 3'd1, 32'h16, 32'h0, 32'h0, 1'b0, 32'hFFFFDEAD);
    issue_exp(1'b0, 3'd5, 32'h16, 32'h0, 32'h0, 1'b0, 32'h0000DEAD);

    // partial stores
    issue_exp(1'b1, 3'd0, 32'h15, 32'h0, 32'hAAAAAA55, 1'b0, 32'h0);
    issue_exp(1'b0, 3'd2, 32'h14, 32'h0, 32'h0, 1'b0, 32'hDEAD55EF);
    issue_exp(1'b1, 3'd1, 32'h16, 32'h0, 32'hFFFF1234, 1'b0, 32'h0);
    issue_exp(1'b0, 3'd2, 32'h14, 32'h0, 32'h0, 1'b0, 32'h123455EF);

    // rejected accesses leave memory alone
    issue_exp(1'b0, 3'd2, 32'h13, 32'h0, 32'h0, 1'b1, 32'h0);
    issue_exp(1'b1, 3'd1, 32'h01, 32'h0, 32'hFFFFFFFF, 1'b1, 32'h0);
    issue_exp(1'b1, 3'd2, 32'h80, 32'h0, 32'hFFFFFFFF, 1'b1, 32'h0);
    issue_exp(1'b0, 3'd3, 32'h14, 32'h0, 32'h0, 1'b1, 32'h0);
    issue_exp(1'b1, 3'd3, 32'h14, 32'h0, 32'hFFFFFFFF, 1'b1, 32'h0);
    issue_exp(1'b0, 3'd2, 32'h7C, 32'h0, 32'h0, 1'b0, 32'h0);
    issue_exp(1'b0, 3'd2, 32'h00, 32'h0, 32'h0, 1'b0, 32'h0);
    issue_exp(1'b0, 3'd2, 32'h14, 32'h0, 32'h0, 1'b0, 32'h123455EF);
    idle(2);

    // wrapping effective address, then back-to-back store/load pairs
    issue_exp(1'b1, 3'd2, 32'h20, 32'hFFFFFFFC, 32'hCAFEF00D, 1'b0, 32'h0);
    issue_exp(1'b0, 3'd2, 32'h20, 32'hFFFFFFFC, 32'h0, 1'b0, 32'hCAFEF00D);
    for (int i = 0; i < 16; i++) begin
      ea_t = 32'($urandom_range(0, DEPTH-1)) << 2;
      wd   = $urandom;
      issue(1'b1, 3'd2, ea_t, 32'h0, wd);
      issue(1'b0, 3'd2, ea_t, 32'h0, 32'h0);
    end

    // randomized mix
    for (int i = 0; i < 400; i++) begin
      ea_t = 32'($urandom_range(0, 4*DEPTH + 8));
      if ($urandom_range(0, 15) == 0) ea_t = $urandom;
      off = 32'($urandom_range(0, 64)) - 32'd32;
      f3  = 3'($urandom_range(0, 7));
      we  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0) f3 = {1'b0, f3[1:0] == 2'b11 ? 2'b10 : f3[1:0]};
      issue(we, f3, ea_t - off, off, $urandom);
      if ($urandom_range(0, 7) == 0) idle(1);
    end
    idle(3);
    check("drain", 32'(exp_q.size()), 32'h0);

    // fill memory so the re-sweep has something to clear
    for (int i = 0; i < DEPTH; i++) issue(1'b1, 3'd2, 32'(4*i), 32'h0, $urandom | 32'h1);
    idle(2);

    // reset during a response
    issue(1'b0, 3'd2, 32'h14, 32'h0, 32'h0);
    @(posedge clk);
    #1 check("mid_resp_valid_before", 32'(resp_valid), 32'h1);
    #1 rst_n = 1'b0; req_valid = 1'b0;
    #1 check("mid_resp_valid_after", 32'(resp_valid), 32'h0);
    check("mid_resp_rdata_after", resp_rdata, 32'h0);
    check("mid_resp_init_done", 32'(init_done), 32'h0);
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // reset in the middle of the sweep, then a full sweep again
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check("mid_sweep_init_done", 32'(init_done), 32'h0);
    check("mid_sweep_req_ready", 32'(req_ready), 32'h0);
    #2 rst_n = 1'b1;
    wait_init();
    for (int i = 0; i < DEPTH; i++) issue_exp(1'b0, 3'd2, 32'(4*i), 32'h0, 32'h0, 1'b0, 32'h0);
    idle(3);
    check("final_drain", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
